div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU, sitting beside the EX stage.
- EX drives operands and start, and holds `stallreq_from_ex` high while the operation runs.
- EX consumes the 64-bit {remainder, quotient} result, which it writes to HI/LO.
- Handles signed and unsigned division, divide-by-zero, and annulment by a pipeline flush.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high (`RstEnable`).
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  `DivStart` request from EX; level-held until ready_o.
- annul_i  in  1  abort the current operation (flush or exception).
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  `DivResultReady` when result_o is valid.

Behaviour:
- Reset:
  - state = DivFree; result_o = 0; ready_o = 0; counter = 0.
  - Reset asserted mid-operation aborts immediately; no partial result is emitted.
- Outputs: all are registered; there is no combinational path from input to output.
- DivFree:
  - Waits for start_i=1 && annul_i=0.
  - If opdata2_i == 0, go to DivByZero.
  - Otherwise latch magnitudes and signs, clear the counter, go to DivOn.
  - Magnitude: the two's-complement negation when signed_div_i=1 and the operand MSB is 1; else the raw value.
  - start_i while annul_i=1 is ignored.
- DivByZero: next edge goes to DivEnd with result_o = 0.
- DivOn, with annul_i=1: go to DivFree; ready_o = 0; result_o = 0.
- DivOn, counter != WIDTH, one restoring step per cycle:
  - partial = {rem[WIDTH-1:0], dividend MSB}.
  - If partial >= divisor: subtract and shift in quotient bit 1; else shift in 0.
  - counter++.
- DivOn, counter == WIDTH: apply signs, go to DivEnd.
  - Quotient is negated iff signed && dividend sign != divisor sign.
  - Remainder is negated iff signed && dividend negative.
- DivEnd: ready_o = 1; result_o held stable.
  - When start_i = 0 (`DivStop`): go to DivFree, clear ready_o and result_o.
- Latency:
  - Start-sampling edge = E0; steps on E1..E32; sign fix on E33.
  - ready_o is high after E33 and stays high until EX drops start_i.
  - Divide-by-zero: ready_o is high after E1.
- Start while busy: start_i is ignored outside DivFree; operands are latched only at E0.
- Operand changes after E0 have no effect.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): result q = 0x80000000, r = 0 (wraps naturally; no trap).
- annul_i has no effect in DivFree or DivEnd; in DivByZero it returns to DivFree.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - In DivFree, if divisor != 0 and |dividend| < |divisor|, go straight to DivEnd at E0.
  - Result: quotient 0, remainder = original opdata1_i; ready_o high after E0.
- Undefined: every nonzero-divisor operation takes the full 33-edge path.
- Results are identical either way; only latency differs.

Decomposition:
- defines.v gains:
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits).
  - `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`.
  - `ZeroWord`, reused.
- No sub-module: a single step expression and a negate function suffice inside div_unit.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed=0, start held -> ready_o after E33, result_o = 0x00000002_0000000E.
- Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> result_o = 0xFFFFFFFF_FFFFFFFD (r=-1, q=-3); opdata1=0x80000000, opdata2=0xFFFFFFFF -> 0x00000000_80000000.
- Divide-by-zero: opdata1=5, opdata2=0 -> ready_o after E1, result_o = 0; start_i dropped -> ready_o=0 next edge.
- Annul then restart: annul_i pulse at E10 of 0xFFFFFFFF/0x10 -> state DivFree, ready_o stays 0; new start 9/3 -> 0x00000000_00000003 after E33.
- Async reset mid-DivOn (E15): outputs 0 immediately without a clock edge; a post-reset 0xFFFFFFFF/0x10 unsigned gives 0x0000000F_0FFFFFFF.
- With DIV_FAST_PATH_EN: 3/10 unsigned -> ready_o after E0, result_o = 0x00000003_00000000; without it, same result after E33.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared state encodings and handshake levels for the multi-cycle divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU); result {rem, quo}. Optional macro DIV_FAST_PATH_EN.
// Latency: ready after E33 (E1 for /0, E0 on fast path); start_i level-held until ready_o.
// EX holds result by keeping start_i high; dropping start_i releases the unit.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       partial;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_neg, b_neg;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    ready_d  = ready_q;

    a_neg   = signed_div_i & opdata1_i[WIDTH-1];
    b_neg   = signed_div_i & opdata2_i[WIDTH-1];
    a_mag   = a_neg ? neg(opdata1_i) : opdata1_i;
    b_mag   = b_neg ? neg(opdata2_i) : opdata2_i;
    partial = {rem_q, dvd_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};

    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
`ifdef DIV_FAST_PATH_EN
          end else if (a_mag < b_mag) begin
            state_d  = DIV_END;
            result_d = {opdata1_i, {WIDTH{1'b0}}};
            ready_d  = DIV_RESULT_READY;
`endif
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q != CNT_DONE) begin
          // diff MSB is the borrow: clear means partial >= divisor
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = partial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {r_neg_q ? neg(rem_q) : rem_q, q_neg_q ? neg(dvd_q) : dvd_q};
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, popped on ready_o.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 64'h0000_0000_8000_0000;
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

`ifdef DIV_FAST_PATH_EN
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction
`endif

  // Issue one op, scramble operands after E0, wait for ready, check result/hold/release.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input bit rst_at_end);
    int lat;
    int exp_lat;
    logic [63:0] want;
    exp_lat = (b == 32'h0) ? 2 : 34;
`ifdef DIV_FAST_PATH_EN
    if (b != 32'h0 && mag(a, s) < mag(b, s)) exp_lat = 1;
`endif
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      if (ready_o) break;
    end
    check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    want = exp_q.pop_front();
    check_eq({tag, ".res"}, result_o, want);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".hold_rdy"}, 64'(ready_o), 64'd1);
    check_eq({tag, ".hold_res"}, result_o, want);
    if (rst_at_end) begin
      #1 rst = 1'b1;
      #1;
      check_eq({tag, ".arst_rdy"}, 64'(ready_o), 64'd0);
      check_eq({tag, ".arst_res"}, result_o, 64'h0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, ".stop_rdy"}, 64'(ready_o), 64'd0);
      check_eq({tag, ".stop_res"}, result_o, 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit rose;
    logic [31:0] a, b;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_rdy", 64'(ready_o), 64'd0);
    check_eq("reset_res", result_o, 64'h0);
    rst = 1'b0;

    do_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 1'b0);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
    do_div("dbz", 32'd5, 32'd0, 1'b0, 64'h0, 1'b0);
    do_div("u3_10", 32'd3, 32'd10, 1'b0, 64'h0000_0003_0000_0000, 1'b0);

    // start with annul held must not launch an op
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd0; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("annul_free_rdy", 64'(ready_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    // annul at E10 of a long op
    @(negedge clk);
    opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'h10; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    check_eq("annul_rdy", 64'(ready_o), 64'd0);
    check_eq("annul_res", result_o, 64'h0);
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rose = 1'b1;
    end
    check_eq("annul_quiet", 64'(rose), 64'd0);
    do_div("u9_3", 32'd9, 32'd3, 1'b0, 64'h0000_0000_0000_0003, 1'b0);

    // async reset at E15 of an op
    @(negedge clk);
    opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'h10; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_mid_rdy", 64'(ready_o), 64'd0);
    check_eq("arst_mid_res", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div("post_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 64'h0000_000F_0FFF_FFFF, 1'b0);

    // async reset while a result is being held
    do_div("arst_end", 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 1'b1);

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) a = $urandom_range(0, 20);
      if (i % 4 == 1) b = -32'($urandom_range(1, 9));
      if (i % 5 == 2) b = $urandom_range(1, 1000);
      do_div($sformatf("rnd%0d", i), a, b, 1'(i % 2), model(a, b, 1'(i % 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
